// File: rtl/seq_det_pkg.sv
// Types and constants shared by the sequence detector, its stream feeder and
// their benches.
package seq_det_pkg;

    // Default detector target width; the detector and the feeder must agree.
    localparam int SEQ_D_WIDTH = 5;

    // Width of the counter that times how long det_resetn is held low.
    localparam int RST_CNT_W = 4;

    typedef enum logic [1:0] {
        NOCFG = 2'd0,
        LOAD  = 2'd1,
        IDLE  = 2'd2,
        SHIFT = 2'd3
    } feeder_state_t;

endpackage

// File: rtl/seq_piso_shift.sv
// Parallel-in/serial-out word shifter. bit_out and last describe the bit that
// will be on the serial line after the coming clock edge.
module seq_piso_shift #(
    parameter int WORD_W    = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              shift,
    input  logic [WORD_W-1:0] data,
    output logic              bit_out,
    output logic              last
);

    localparam int CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    logic [WORD_W-1:0] sreg;
    logic [WORD_W-1:0] sreg_nxt;
    logic [CNT_W-1:0]  cnt;

    function automatic logic lead_bit(input logic [WORD_W-1:0] w);
        return (MSB_FIRST != 0) ? w[WORD_W-1] : w[0];
    endfunction

    assign sreg_nxt = (MSB_FIRST != 0) ? (sreg << 1) : (sreg >> 1);

    // The leading bit of a freshly loaded word goes straight to the output
    // register, so the first bit appears one cycle after the handshake.
    assign bit_out = load ? lead_bit(data) : lead_bit(sreg_nxt);

    // cnt counts bits still to come after the one currently presented.
    assign last = load ? (WORD_W == 1) : (cnt == CNT_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sreg <= '0;
            cnt  <= '0;
        end else if (load) begin
            sreg <= data;
            cnt  <= CNT_W'(WORD_W - 1);
        end else if (shift) begin
            sreg <= sreg_nxt;
            cnt  <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/seq_stream_feeder.sv
// Feeds the programmable sequence detector: loads its target under a
// det_resetn pulse, then serialises handshaked words onto det_din.
module seq_stream_feeder
    import seq_det_pkg::*;
#(
    parameter int D_WIDTH      = SEQ_D_WIDTH,
    parameter int WORD_W       = 8,
    parameter int MSB_FIRST    = 1,
    parameter int RESET_CYCLES = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [D_WIDTH-1:0] cfg_target,
    input  logic               cfg_load,
    input  logic [WORD_W-1:0]  s_data,
    input  logic               s_valid,
    output logic               s_ready,
    output logic               det_resetn,
    output logic [D_WIDTH-1:0] det_init,
    output logic               det_din,
    output logic               det_valid,
    output logic               word_done,
    output logic               busy
);

    feeder_state_t        state;
    feeder_state_t        next_state;
    logic [RST_CNT_W-1:0] rcnt;

    logic load;
    logic shift;
    logic bit_out;
    logic last;

    logic det_resetn_d;
    logic det_valid_d;
    logic det_din_d;
    logic word_done_d;
    logic busy_d;

    seq_piso_shift #(
        .WORD_W    (WORD_W),
        .MSB_FIRST (MSB_FIRST)
    ) u_piso (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .shift   (shift),
        .data    (s_data),
        .bit_out (bit_out),
        .last    (last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= NOCFG;
            rcnt       <= '0;
            det_init   <= '0;
            det_resetn <= 1'b0;
            det_din    <= 1'b0;
            det_valid  <= 1'b0;
            word_done  <= 1'b0;
            busy       <= 1'b1;
        end else begin
            state      <= next_state;
            det_resetn <= det_resetn_d;
            det_din    <= det_din_d;
            det_valid  <= det_valid_d;
            word_done  <= word_done_d;
            busy       <= busy_d;
            if (cfg_load) begin
                det_init <= cfg_target;
                rcnt     <= RST_CNT_W'(RESET_CYCLES - 1);
            end else if (state == LOAD && rcnt != '0) begin
                rcnt <= rcnt - RST_CNT_W'(1);
            end
        end
    end

    // cfg_load overrides everything, including a word in flight.
    always_comb begin
        next_state = state;
        if (cfg_load) begin
            next_state = LOAD;
        end else begin
            case (state)
                NOCFG:   next_state = NOCFG;
                LOAD:    if (rcnt == '0) next_state = IDLE;
                IDLE:    if (s_valid) next_state = SHIFT;
                SHIFT:   if (word_done && !s_valid) next_state = IDLE;
                default: next_state = NOCFG;
            endcase
        end
    end

    // word_done marks the last-bit cycle, which is also the only SHIFT cycle
    // in which the next word may be taken.
    always_comb begin
        s_ready      = !cfg_load && (state == IDLE || (state == SHIFT && word_done));
        load         = s_valid && s_ready;
        shift        = (state == SHIFT) && !word_done && !cfg_load;
        det_resetn_d = (next_state == IDLE) || (next_state == SHIFT);
        det_valid_d  = (next_state == SHIFT);
        det_din_d    = (load || shift) ? bit_out : det_din;
        word_done_d  = (load || shift) && last;
        busy_d       = (next_state != IDLE);
    end

endmodule

// File: doc/seq_stream_feeder.md
Name: seq_stream_feeder

Overview:
- Upstream driver for the programmable sequence detector. Accepts parallel data words over a valid/ready handshake and loads a target pattern on request.
- Serialises each word onto the detector's single-bit din, one bit per clock.
- Sequences the detector's resetn/init pins so that a new target is loaded before any new bits are streamed.

Parameters:
D_WIDTH, 5, width of the detector target pattern (init)
WORD_W, 8, width of each input data word
MSB_FIRST, 1, 1 = serialise bit WORD_W-1 first; 0 = bit 0 first
RESET_CYCLES, 1, number of cycles det_resetn is held low per target load (valid range 1..15)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
cfg_target  in  D_WIDTH  target pattern to load into the detector
cfg_load  in  1  single-cycle request to load cfg_target; may be asserted in any state
s_data  in  WORD_W  input data word
s_valid  in  1  s_data valid
s_ready  out  1  feeder can accept a word this cycle
det_resetn  out  1  detector reset, active low
det_init  out  D_WIDTH  detector target pattern
det_din  out  1  serial bit to the detector
det_valid  out  1  det_din carries a live stream bit
word_done  out  1  pulse coincident with the last bit of each word
busy  out  1  state is not IDLE

Behaviour:
- Reset (async assert, sync release):
  - State becomes NOCFG.
  - det_resetn=0, det_init=0, det_din=0, det_valid=0, word_done=0, busy=1.
  - Shift register and bit counter clear.
- All det_* outputs, word_done and busy are registered. s_ready is combinational from state, counter and cfg_load.
- State NOCFG:
  - det_resetn held 0; s_ready=0.
  - cfg_load moves to LOAD.
- State LOAD:
  - Entered on cfg_load sampled from any state. cfg_target is captured into det_init at that edge.
  - det_resetn=0 for exactly RESET_CYCLES cycles, then goes to 1 on the transition to IDLE.
  - s_ready=0 throughout.
  - A new cfg_load while in LOAD recaptures the target and restarts the count.
- State IDLE:
  - det_resetn=1, det_valid=0, s_ready=~cfg_load.
  - Handshake s_valid&s_ready at edge k: word enters the shift register, counter=WORD_W-1, state moves to SHIFT.
  - The first bit appears on det_din with det_valid=1 in cycle k+1 (latency 1 cycle).
- State SHIFT:
  - Each cycle drives one bit and det_valid=1.
  - Bit order: MSB_FIRST=1 gives s_data[WORD_W-1] down to [0]; MSB_FIRST=0 gives [0] up to [WORD_W-1].
  - Counter decrements once per bit. word_done=1 in the cycle carrying the last bit.
  - In the last-bit cycle s_ready=~cfg_load:
    - Handshake in that cycle: the next word begins the following cycle, with no gap in det_valid.
    - No handshake: return to IDLE and det_valid=0 next cycle.
- cfg_load during SHIFT:
  - The current word is aborted and its remaining bits are discarded.
  - det_valid=0 from the next cycle; state moves to LOAD.
  - word_done does not pulse for the aborted word.
- Simultaneous cfg_load and s_valid: cfg_load wins, s_ready=0, and the word is not consumed.
- det_din is held at its last value when det_valid=0. The detector samples din every clock, so idle bits are presented as stable, not random.
- busy=1 in NOCFG, LOAD and SHIFT.
- The counter is $clog2(WORD_W) bits wide. The reset-cycle counter is 4 bits wide. No wrap-around is possible because both counters are reloaded on each entry to their state.

Decomposition:
- Package seq_det_pkg:
  - feeder_state_t enum {NOCFG, LOAD, IDLE, SHIFT}.
  - Default D_WIDTH=5, shared with the detector and its bench.
- One sub-module, seq_piso_shift (parameters WORD_W, MSB_FIRST):
  - Ports: load, shift, data, bit_out, last.
  - Holds the shift register and bit counter.
  - The FSM, handshake and detector-reset sequencing stay in the top module.

Test Plan:
1. reset pulse, then cfg_load with cfg_target=5'b11011 -> det_init=11011; det_resetn low exactly 1 cycle; s_ready=1 on the following cycle; busy drops to 0.
2. Word 8'b10111110 with MSB_FIRST=1 -> det_din sequence 1,0,1,1,1,1,1,0 on 8 consecutive cycles; det_valid high exactly 8 cycles; word_done on the 8th cycle only.
3. Back-to-back words 8'hA5 then 8'h3C with s_valid held high -> 16 contiguous det_valid cycles, bits 10100101 00111100; s_ready high only in the IDLE cycle and the two last-bit cycles.
4. cfg_load with cfg_target=5'b11110 during the 4th bit of a word -> det_valid=0 next cycle; det_init=11110; det_resetn low RESET_CYCLES cycles; no word_done; the remaining 4 bits never appear.
5. s_valid=1 before any cfg_load -> s_ready stays 0 and det_resetn stays 0 indefinitely; after cfg_load the pending word is accepted in the first IDLE cycle.
6. Assert reset asynchronously mid-SHIFT (between clock edges) -> det_valid, det_din and det_resetn go to 0 immediately without a clock edge; state returns to NOCFG.
